// File: rtl/mask_bbox_pkg.sv
// Shared types and constants for the mask_bbox foreground bounding-box block.
package mask_bbox_pkg;

    typedef enum logic {
        S_READ   = 1'b0,
        S_REPORT = 1'b1
    } state_t;

    localparam logic [7:0] MASK_FG = 8'hFF;
    localparam logic [7:0] MASK_BG = 8'h00;

endpackage

// File: rtl/mask_bbox_if.sv
// Mask FIFO read port plus per-frame result handshake for mask_bbox.
interface mask_bbox_if #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
);
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic          mask_fifo_empty;
    logic [7:0]    mask_data;
    logic          RE;
    logic          result_valid;
    logic          result_ready;
    logic [CW-1:0] fg_count;
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic          motion;
    logic [15:0]   frame_id;

    modport slave (
        input  mask_fifo_empty, mask_data, result_ready,
        output RE, result_valid, fg_count, x_min, x_max, y_min, y_max, motion, frame_id
    );

    modport master (
        output mask_fifo_empty, mask_data, result_ready,
        input  RE, result_valid, fg_count, x_min, x_max, y_min, y_max, motion, frame_id
    );

endinterface

// File: rtl/mask_bbox_accum.sv
// Foreground count and bounding-box accumulators; o_next_* is the value after this cycle's update.
module mask_bbox_accum #(
    parameter int CW = 8,
    parameter int XW = 4,
    parameter int YW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_update,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic [CW-1:0] o_next_count,
    output logic [XW-1:0] o_next_x_min,
    output logic [XW-1:0] o_next_x_max,
    output logic [YW-1:0] o_next_y_min,
    output logic [YW-1:0] o_next_y_max
);

    logic [CW-1:0] r_count;
    logic [XW-1:0] r_x_min;
    logic [XW-1:0] r_x_max;
    logic [YW-1:0] r_y_min;
    logic [YW-1:0] r_y_max;

    // A zero count means the box is still empty, so the first hit seeds min and max.
    always_comb begin
        o_next_count = r_count;
        o_next_x_min = r_x_min;
        o_next_x_max = r_x_max;
        o_next_y_min = r_y_min;
        o_next_y_max = r_y_max;
        if (i_update) begin
            o_next_count = r_count + 1'b1;
            if (r_count == '0) begin
                o_next_x_min = i_x;
                o_next_x_max = i_x;
                o_next_y_min = i_y;
                o_next_y_max = i_y;
            end else begin
                if (i_x < r_x_min) o_next_x_min = i_x;
                if (i_x > r_x_max) o_next_x_max = i_x;
                if (i_y < r_y_min) o_next_y_min = i_y;
                if (i_y > r_y_max) o_next_y_max = i_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
            r_x_min <= '0;
            r_x_max <= '0;
            r_y_min <= '0;
            r_y_max <= '0;
        end else begin
            r_count <= o_next_count;
            r_x_min <= o_next_x_min;
            r_x_max <= o_next_x_max;
            r_y_min <= o_next_y_min;
            r_y_max <= o_next_y_max;
        end
    end

endmodule

// File: rtl/mask_bbox.sv
// Raster-scans a binary mask stream and reports per-frame foreground count and bounding box.
// Define MASK_BBOX_FRAME_ID_EN to enable the accepted-result frame_id counter.
module mask_bbox
    import mask_bbox_pkg::*;
#(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int MIN_PIXELS = 64
) (
    input logic        clk,
    input logic        rst,
    mask_bbox_if.slave bus
);

    localparam int CW = $clog2(WIDTH * HEIGHT + 1);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(HEIGHT - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_re;
    logic          w_accept;
    logic          w_last;
    logic          w_update;
    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;

    logic [CW-1:0] w_next_count;
    logic [XW-1:0] w_next_x_min;
    logic [XW-1:0] w_next_x_max;
    logic [YW-1:0] w_next_y_min;
    logic [YW-1:0] w_next_y_max;

    logic [CW-1:0] r_fg_count;
    logic [XW-1:0] r_x_min;
    logic [XW-1:0] r_x_max;
    logic [YW-1:0] r_y_min;
    logic [YW-1:0] r_y_max;
    logic          r_motion;

    assign w_last   = (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_update = w_re && (bus.mask_data != MASK_BG);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_READ;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_re         = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            S_READ: begin
                w_re = !bus.mask_fifo_empty;
                if (w_re && w_last) w_state_next = S_REPORT;
            end
            S_REPORT: begin
                if (bus.result_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_READ;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_re) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    mask_bbox_accum #(
        .CW (CW),
        .XW (XW),
        .YW (YW)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_accept),
        .i_update     (w_update),
        .i_x          (r_col),
        .i_y          (r_row),
        .o_next_count (w_next_count),
        .o_next_x_min (w_next_x_min),
        .o_next_x_max (w_next_x_max),
        .o_next_y_min (w_next_y_min),
        .o_next_y_max (w_next_y_max)
    );

    // Capture from the accumulator's next values so the final pixel is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fg_count <= '0;
            r_x_min    <= '0;
            r_x_max    <= '0;
            r_y_min    <= '0;
            r_y_max    <= '0;
            r_motion   <= 1'b0;
        end else if (w_re && w_last) begin
            r_fg_count <= w_next_count;
            r_x_min    <= w_next_x_min;
            r_x_max    <= w_next_x_max;
            r_y_min    <= w_next_y_min;
            r_y_max    <= w_next_y_max;
            r_motion   <= (int'(w_next_count) >= MIN_PIXELS);
        end
    end

    assign bus.RE           = w_re;
    assign bus.result_valid = (r_state == S_REPORT);
    assign bus.fg_count     = r_fg_count;
    assign bus.x_min        = r_x_min;
    assign bus.x_max        = r_x_max;
    assign bus.y_min        = r_y_min;
    assign bus.y_max        = r_y_max;
    assign bus.motion       = r_motion;

`ifdef MASK_BBOX_FRAME_ID_EN
    logic [15:0] r_frame_id;

    always_ff @(posedge clk) begin
        if (rst)           r_frame_id <= '0;
        else if (w_accept) r_frame_id <= r_frame_id + 16'd1;
    end

    assign bus.frame_id = r_frame_id;
`else
    assign bus.frame_id = '0;
`endif

endmodule

// File: tb/tb_mask_bbox.sv
// Self-checking bench for mask_bbox: show-ahead FIFO model, randomized stalls, column/row projection reference.
module tb_mask_bbox;
    import mask_bbox_pkg::*;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int MINP = 2;
    localparam int NPIX = W * H;
    localparam int CW   = $clog2(W * H + 1);
    localparam int XW   = $clog2(W);
    localparam int YW   = $clog2(H);
    localparam int RW   = CW + 2 * XW + 2 * YW + 17;
`ifdef MASK_BBOX_FRAME_ID_EN
    localparam int FID_STEP = 1;
`else
    localparam int FID_STEP = 0;
`endif

    typedef struct {
        int cnt;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mask_bbox_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    mask_bbox #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .MIN_PIXELS (MINP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]    stim [128];
    int            stim_len  = 0;
    int            rd_idx    = 0;
    int            stall_pct = 0;
    int            checks    = 0;
    int            errors    = 0;
    logic [RW-1:0] obs;

    assign obs = {bus.fg_count, bus.x_min, bus.x_max, bus.y_min, bus.y_max, bus.motion, bus.frame_id};

    // Reference: project foreground onto columns and rows, box = first/last occupied ones.
    function automatic res_t model(input int base);
        res_t r;
        bit col_has [W];
        bit row_has [H];
        r = '{0, 0, 0, 0, 0};
        for (int i = 0; i < W; i++) col_has[i] = 1'b0;
        for (int i = 0; i < H; i++) row_has[i] = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            if (stim[base + i] != MASK_BG) begin
                r.cnt++;
                col_has[i % W] = 1'b1;
                row_has[i / W] = 1'b1;
            end
        end
        if (r.cnt > 0) begin
            for (int x = W - 1; x >= 0; x--) if (col_has[x]) r.xmin = x;
            for (int x = 0; x < W; x++)      if (col_has[x]) r.xmax = x;
            for (int y = H - 1; y >= 0; y--) if (row_has[y]) r.ymin = y;
            for (int y = 0; y < H; y++)      if (row_has[y]) r.ymax = y;
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] pack(input res_t r, input int fid);
        return {CW'(r.cnt), XW'(r.xmin), XW'(r.xmax), YW'(r.ymin), YW'(r.ymax),
                (r.cnt >= MINP), 16'(fid)};
    endfunction

    // Show-ahead FIFO: head presented after the falling edge, popped on a rising edge with RE high.
    initial begin
        logic have;
        logic stall;
        logic re_s;
        bus.mask_fifo_empty = 1'b1;
        bus.mask_data       = 8'h00;
        forever begin
            @(negedge clk);
            have  = (rd_idx < stim_len);
            stall = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
            bus.mask_fifo_empty = !have || stall;
            bus.mask_data       = have ? stim[rd_idx] : 8'h00;
            #4 re_s = bus.RE;
            @(posedge clk);
            if (rst)                        rd_idx = 0;
            else if (re_s && have && !stall) rd_idx++;
        end
    end

    task automatic reset_begin();
        @(negedge clk);
        rst              = 1'b1;
        stim_len         = 0;
        stall_pct        = 0;
        bus.result_ready = 1'b0;
    endtask

    task automatic reset_end(input int len);
        stim_len = len;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_all_bg();
        int cyc;
        bit ok;
        reset_begin();
        for (int i = 0; i < NPIX; i++) stim[i] = MASK_BG;
        reset_end(NPIX);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            cyc++;
            if (bus.result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || cyc != NPIX) begin
            errors++;
            $display("FAIL all_bg_latency: valid after %0d edges (seen=%0d), expected %0d", cyc, ok, NPIX);
        end
        checks++;
        if (rd_idx != NPIX) begin
            errors++;
            $display("FAIL all_bg_pops: got %0d, expected %0d", rd_idx, NPIX);
        end
        checks++;
        if (obs !== pack('{0, 0, 0, 0, 0}, 0)) begin
            errors++;
            $display("FAIL all_bg_result: got %h, expected %h", obs, pack('{0, 0, 0, 0, 0}, 0));
        end
        accept();
    endtask

    task automatic test_two_fg();
        bit ok;
        reset_begin();
        for (int i = 0; i < NPIX; i++) stim[i] = MASK_BG;
        stim[1 * W + 2] = 8'($urandom_range(1, 255));
        stim[3 * W + 5] = 8'($urandom_range(1, 255));
        reset_end(NPIX);
        wait_valid(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL two_fg_timeout: result_valid=%b, expected 1", bus.result_valid);
        end
        checks++;
        if (obs !== pack('{2, 2, 5, 1, 3}, 0)) begin
            errors++;
            $display("FAIL two_fg_result: got %h, expected %h", obs, pack('{2, 2, 5, 1, 3}, 0));
        end
        accept();
    endtask

    task automatic test_reset();
        bit ok;
        reset_begin();
        for (int i = 0; i < NPIX; i++) stim[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : MASK_BG;
        stim[5] = 8'h3C;
        reset_end(NPIX);
        wait_valid(100, ok);
        reset_begin();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0 || obs !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b outputs=%h, expected valid=0 outputs=0", bus.result_valid, obs);
        end
        for (int i = 0; i < NPIX; i++) stim[i] = MASK_BG;
        stim[0] = 8'h01;
        reset_end(NPIX);
        #2;
        checks++;
        if (bus.RE !== 1'b1) begin
            errors++;
            $display("FAIL reset_re: RE=%b, expected 1", bus.RE);
        end
        wait_valid(100, ok);
        checks++;
        if (!ok || obs !== pack('{1, 0, 0, 0, 0}, 0)) begin
            errors++;
            $display("FAIL reset_pixel00: valid=%b got %h, expected %h", ok, obs, pack('{1, 0, 0, 0, 0}, 0));
        end
        accept();
    endtask

    task automatic test_hold();
        bit ok;
        logic [RW-1:0] cap;
        reset_begin();
        for (int i = 0; i < 2 * NPIX; i++) stim[i] = MASK_BG;
        stim[NPIX - 1] = 8'($urandom_range(1, 255));
        reset_end(2 * NPIX);
        wait_valid(100, ok);
        checks++;
        if (!ok || obs !== pack(model(0), 0)) begin
            errors++;
            $display("FAIL hold_result: valid=%b got %h, expected %h", ok, obs, pack(model(0), 0));
        end
        cap = obs;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.result_valid !== 1'b1 || obs !== cap || bus.RE !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%b RE=%b out=%h, expected valid=1 RE=0 out=%h",
                         i, bus.result_valid, bus.RE, obs, cap);
            end
        end
        bus.result_ready = 1'b1;
        #1;
        checks++;
        if (bus.RE !== 1'b0) begin
            errors++;
            $display("FAIL accept_re: RE=%b, expected 0", bus.RE);
        end
        @(negedge clk);
        bus.result_ready = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b0 || rd_idx != NPIX) begin
            errors++;
            $display("FAIL accept_once: valid=%b pops=%0d, expected valid=0 pops=%0d", bus.result_valid, rd_idx, NPIX);
        end
        wait_valid(100, ok);
        checks++;
        if (!ok || obs !== pack('{0, 0, 0, 0, 0}, FID_STEP)) begin
            errors++;
            $display("FAIL back_to_back: valid=%b got %h, expected %h", ok, obs, pack('{0, 0, 0, 0, 0}, FID_STEP));
        end
        accept();
    endtask

    task automatic test_random_stall();
        bit ok;
        int dens;
        reset_begin();
        for (int f = 0; f < 3; f++) begin
            dens = (f == 0) ? 12 : (f == 1) ? 1 : 3;
            for (int i = 0; i < NPIX; i++)
                stim[f * NPIX + i] = ($urandom_range(0, dens) == 0) ? 8'($urandom_range(1, 255)) : MASK_BG;
        end
        reset_end(3 * NPIX);
        stall_pct        = 40;
        bus.result_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_valid(500, ok);
            checks++;
            if (!ok || obs !== pack(model(f * NPIX), f * FID_STEP)) begin
                errors++;
                $display("FAIL stall_frame%0d: valid=%b got %h, expected %h", f, ok, obs, pack(model(f * NPIX), f * FID_STEP));
            end
        end
        bus.result_ready = 1'b0;
        stall_pct        = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        reset_begin();
        for (int i = 0; i < 13; i++) stim[i] = MASK_FG;
        reset_end(13);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rd_idx == 13) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_pops: got %0d, expected 13", rd_idx);
        end
        reset_begin();
        for (int i = 0; i < NPIX; i++) stim[i] = MASK_FG;
        reset_end(NPIX);
        wait_valid(100, ok);
        checks++;
        if (!ok || obs !== pack('{32, 0, 7, 0, 3}, 0)) begin
            errors++;
            $display("FAIL mid_result: valid=%b got %h, expected %h", ok, obs, pack('{32, 0, 7, 0, 3}, 0));
        end
        accept();
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_single: extra result_valid=1, expected none");
        end
    endtask

    initial begin
        bus.result_ready = 1'b0;
        test_all_bg();
        test_two_fg();
        test_reset();
        test_hold();
        test_random_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mask_bbox.md
MASK_BBOX -- requirements
Module: mask_bbox

Interface
REQ-001 SHALL have parameter WIDTH, default 720, pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 540, rows per frame.
REQ-003 SHALL have parameter MIN_PIXELS, default 64, foreground count at or above which motion is flagged.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mask_fifo_empty  input  1  upstream mask FIFO empty flag.
REQ-007 SHALL have port mask_data  input  8  FIFO head word, valid while mask_fifo_empty=0 (show-ahead).
REQ-008 SHALL have port RE  output  1  pop strobe; head consumed in the same cycle.
REQ-009 SHALL have port result_valid  output  1  per-frame result available.
REQ-010 SHALL have port result_ready  input  1  downstream accepts result.
REQ-011 SHALL have port fg_count  output  $clog2(WIDTH*HEIGHT+1)  foreground pixels in frame.
REQ-012 SHALL have ports x_min, x_max  output  $clog2(WIDTH)  foreground bounding-box columns.
REQ-013 SHALL have ports y_min, y_max  output  $clog2(HEIGHT)  foreground bounding-box rows.
REQ-014 SHALL have port motion  output  1  fg_count >= MIN_PIXELS.
REQ-015 SHALL have port frame_id  output  16  reported frame index (see Configuration).

Function
REQ-016 SHALL classify a pixel as foreground when mask_data != 8'h00, background otherwise.
REQ-017 SHALL implement FSM states S_READ, S_REPORT; reset state S_READ.
REQ-018 In S_READ SHALL assert RE combinationally iff mask_fifo_empty=0; RE=0 in S_REPORT.
REQ-019 SHALL keep col (0..WIDTH-1) and row (0..HEIGHT-1) counters, raster order; col wraps to 0 and row increments on each pop at col=WIDTH-1.
REQ-020 On each foreground pop SHALL increment count and update min/max of x (col) and y (row), compared against the popped pixel's own coordinates.
REQ-021 On the pop at col=WIDTH-1, row=HEIGHT-1 SHALL register results including that pixel, clear col/row, and enter S_REPORT; result_valid high the next cycle (latency 1).
REQ-022 In S_REPORT SHALL hold result_valid=1 and all result outputs stable until result_ready=1 is sampled; then return to S_READ with accumulators cleared that same edge.
REQ-023 result_valid and result_ready both high for one cycle SHALL count as exactly one transfer; RE remains 0 in that cycle.
REQ-024 Frame with zero foreground SHALL report fg_count=0, motion=0, x_min=x_max=y_min=y_max=0.
REQ-025 Empty FIFO mid-frame SHALL stall counters and accumulators without loss; no timeout.
REQ-026 Result outputs SHALL be registered; they are undefined-free (hold last frame) when result_valid=0.

Reset
REQ-027 On rst=1 at a rising edge SHALL set state S_READ, col=row=0, accumulators cleared, result_valid=0, all result outputs 0, frame_id=0.
REQ-028 Reset mid-frame or during S_REPORT SHALL discard the partial/pending frame; next pop is treated as pixel (0,0).

Configuration
REQ-029 Macro MASK_BBOX_FRAME_ID_EN defined: frame_id SHALL increment by 1 (wrapping 16'hFFFF->0) on each accepted result, first frame reported as 0.
REQ-030 Macro undefined: frame_id SHALL be constant 0 and no counter logic synthesized.

Structure
REQ-031 Package mask_bbox_pkg SHALL hold state_t enum (S_READ, S_REPORT) and constants MASK_FG=8'hFF, MASK_BG=8'h00.
REQ-032 Sub-module mask_bbox_accum SHALL hold count/min/max accumulators with clear and update inputs; FSM and raster counters stay in mask_bbox.

Verification (WIDTH=8, HEIGHT=4, MIN_PIXELS=2)
REQ-033 All 32 pixels 8'h00, FIFO never empty -> one result after 32 RE pulses: fg_count=0, motion=0, bbox all 0, result_valid on cycle 33.
REQ-034 Foreground at (2,1),(5,3) only -> fg_count=2, motion=1, x_min=2, x_max=5, y_min=1, y_max=3.
REQ-035 Single foreground at (7,3) (last pixel), result_ready held 0 for 10 cycles -> result_valid and outputs stable 10 cycles, RE=0 throughout, fg_count=1, motion=0.
REQ-036 FIFO empty toggled randomly across 3 frames, result_ready always 1 -> three results matching golden model; frame_id 0,1,2 with macro, 0,0,0 without.
REQ-037 rst=1 after 13 pops of an all-8'hFF frame, then clean 32-pixel all-8'hFF frame -> single result fg_count=32, bbox (0,7,0,3).
